// File: rtl/program_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> instruction memory words, then core release.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    output logic                  core_run_o,
    output logic                  load_done_o,
    output logic                  load_error_o,
    output logic [ADDR_WIDTH-1:0] word_count_o
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLenHi = 3'd1,
        StLenLo = 3'd2,
        StData  = 3'd3,
        StWrite = 3'd4,
        StRun   = 3'd5,
        StError = 3'd6
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        StChk   = 3'd7
`endif
    } state_e;

    // State entered once the last word is written (or immediately for N=0).
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_e StDone = StChk;
`else
    localparam state_e StDone = StRun;
`endif

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  byte_ready_q, byte_ready_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
    logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    logic                  core_run_q, core_run_d;
    logic                  load_error_q, load_error_d;

    logic                  xfer;
    logic [15:0]           len_full;

    assign xfer     = byte_valid_i & byte_ready_q;
    assign len_full = {len_q[15:8], byte_i};

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            len_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            word_cnt_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            word_cnt_q <= word_cnt_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        word_cnt_d = word_cnt_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            StIdle, StRun, StError: begin
                if (load_start_i) begin
                    state_d    = StLenHi;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    word_cnt_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_d[15:8] = byte_i;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d[7:0] = byte_i;
                    if (len_full == 16'd0) begin
                        state_d = StDone;
                    end else if (32'(len_full) > DEPTH_WORDS) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    asm_d      = {asm_q[DATA_WIDTH-9:0], byte_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ byte_i;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                word_cnt_d = word_cnt_q + 1'b1;
                state_d    = (32'(word_cnt_d) == 32'(len_q)) ? StDone : StData;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            StChk: begin
                if (xfer) begin
                    state_d = (byte_i == csum_q) ? StRun : StError;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        byte_ready_d  = 1'b0;
        mem_wr_en_d   = 1'b0;
        core_run_d    = 1'b0;
        load_error_d  = 1'b0;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        unique case (state_d)
            StLenHi, StLenLo, StData: byte_ready_d = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            StChk: byte_ready_d = 1'b1;
`endif
            StWrite: begin
                mem_wr_en_d   = 1'b1;
                mem_wr_addr_d = word_cnt_q;
                mem_wr_data_d = asm_d;
            end
            StRun:   core_run_d   = 1'b1;
            StError: load_error_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_ready_q  <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            core_run_q    <= 1'b0;
            load_error_q  <= 1'b0;
        end else begin
            byte_ready_q  <= byte_ready_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            core_run_q    <= core_run_d;
            load_error_q  <= load_error_d;
        end
    end

    assign byte_ready_o  = byte_ready_q;
    assign mem_wr_en_o   = mem_wr_en_q;
    assign mem_wr_addr_o = mem_wr_addr_q;
    assign mem_wr_data_o = mem_wr_data_q;
    assign core_run_o    = core_run_q;
    assign load_done_o   = core_run_q;
    assign load_error_o  = load_error_q;
    assign word_count_o  = word_cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed images plus randomized images and handshake gaps.
module tb_program_loader;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        core_run;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;

    program_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_start_i (load_start),
        .byte_i       (byte_in),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .mem_wr_en_o  (mem_wr_en),
        .mem_wr_addr_o(mem_wr_addr),
        .mem_wr_data_o(mem_wr_data),
        .core_run_o   (core_run),
        .load_done_o  (load_done),
        .load_error_o (load_error),
        .word_count_o (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img_words[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (rst_n && mem_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         mem_wr_addr, mem_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
                check("wr_data", mem_wr_data, e.data);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Offers one byte from a negedge until accepted; gap adds idle cycles with junk on byte_in
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  n;
        bit  rdy;
        n = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        forever begin
            rdy = byte_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL byte_accept_timeout: got no ready expected accept of 0x%0h", b);
                break;
            end
        end
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_end(input bit exp_run, input logic [15:0] exp_wc);
        int n;
        n = 0;
        while (!core_run && !load_error && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL load_end_timeout: got no run/error expected run=%0d", exp_run);
        end
        check("core_run", 32'(core_run), 32'(exp_run));
        check("load_done", 32'(load_done), 32'(exp_run));
        check("load_error", 32'(load_error), 32'(!exp_run));
        check("word_count", 32'(word_count), 32'(exp_wc));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    // Reference: builds stream from img_words, queues expected writes, predicts outcome
    task automatic run_image(input logic [15:0] n, input bit rand_gap, input bit bad_csum);
        logic [7:0] bytes[$];
        logic [7:0] x;
        bit         exp_run;
        bit         was_run;
        logic [15:0] exp_wc;
        x       = 8'h00;
        was_run = core_run;
        bytes.push_back(n[15:8]);
        bytes.push_back(n[7:0]);
        if (32'(n) > DEPTH) begin
            exp_run = 1'b0;
            exp_wc  = 16'd0;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                wr_t w;
                w.addr = 16'(i);
                w.data = img_words[i];
                exp_q.push_back(w);
                for (int k = 3; k >= 0; k--) begin
                    logic [31:0] wd;
                    wd = img_words[i];
                    bytes.push_back(wd[k*8 +: 8]);
                    x ^= wd[k*8 +: 8];
                end
            end
            exp_wc  = n;
            exp_run = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            bytes.push_back(bad_csum ? (x ^ 8'h01) : x);
            exp_run = !bad_csum;
`endif
        end
        pulse_start();
        if (was_run) check("core_run_drop", 32'(core_run), 32'd0);
        check("ready_after_start", 32'(byte_ready), 32'd1);
        foreach (bytes[i]) send_byte(bytes[i], rand_gap ? int'($urandom_range(0, 3)) : 0);
        wait_end(exp_run, exp_wc);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_wr_addr), 32'd0);
        check("rst_data", mem_wr_data, 32'd0);
        check("rst_run", 32'(core_run), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'(byte_ready), 32'd0);

        // Two-word image, back-to-back then with alternating valid
        img_words = '{32'h20010005, 32'h8C220004};
        run_image(16'd2, 1'b0, 1'b0);
        pulse_start();
        check("core_run_drop", 32'(core_run), 32'd0);
        begin
            logic [7:0] b2[$];
            b2 = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
            exp_q.push_back('{16'd0, 32'h20010005});
            exp_q.push_back('{16'd1, 32'h8C220004});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            b2.push_back(8'h20 ^ 8'h01 ^ 8'h05 ^ 8'h8C ^ 8'h22 ^ 8'h04);
`endif
            foreach (b2[i]) send_byte(b2[i], 1);
            wait_end(1'b1, 16'd2);
        end

        // Oversized length
        run_image(16'h0401, 1'b0, 1'b0);

        // Reset in the middle of a word: nothing written, everything cleared
        pulse_start();
        check("error_cleared", 32'(load_error), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(byte_ready), 32'd0);
        check("arst_wr_en", 32'(mem_wr_en), 32'd0);
        check("arst_data", mem_wr_data, 32'd0);
        check("arst_addr", 32'(mem_wr_addr), 32'd0);
        check("arst_wc", 32'(word_count), 32'd0);
        check("arst_error", 32'(load_error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_image(16'd2, 1'b0, 1'b0);

        // Reload from RUN
        img_words = '{32'hDEADBEEF};
        run_image(16'd1, 1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        img_words = '{32'h11223344};
        run_image(16'd1, 1'b0, 1'b0);
        run_image(16'd1, 1'b0, 1'b1);
`endif

        // Empty image
        run_image(16'd0, 1'b0, 1'b0);

        for (int it = 0; it < 25; it++) begin
            logic [15:0] n;
            bit          bad;
            n = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) n = 16'(DEPTH + 1 + $urandom_range(0, 2000));
            img_words.delete();
            for (int i = 0; i < 6; i++) img_words.push_back($urandom);
            bad = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            bad = ($urandom_range(0, 3) == 0);
`endif
            run_image(n, 1'($urandom_range(0, 1)), bad);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
